// File: rtl/bus_pkg.sv
// Shared types and default constants for the round-robin bus arbiter.
// Optional contention statistics are enabled with the BUS_RR_STATS_EN macro.
package bus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } bus_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NSRC  = 24;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first requester after last_idx
// (wrapping NSRC-1 -> 0) wins, so the previous winner has the lowest priority.
module rr_pick
    import bus_pkg::*;
#(
    parameter int NSRC  = DEF_NSRC,
    parameter int IDX_W = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]  req,
    input  logic [IDX_W-1:0] last_idx,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);

    // One extra bit so last_idx + offset cannot overflow before the wrap.
    logic [IDX_W:0] sum;

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        any     = 1'b0;
        win_idx = '0;
        sum     = '0;
        for (int k = NSRC; k >= 1; k--) begin
            sum = {1'b0, last_idx} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NSRC)) begin
                sum = sum - (IDX_W + 1)'(NSRC);
            end
            if (req[sum[IDX_W-1:0]]) begin
                any     = 1'b1;
                win_idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Registered round-robin shared bus with ownership lock and registered grant.
// Define BUS_RR_STATS_EN to build the saturating contention counter.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int IDX_W = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  lock,
    output logic [NSRC-1:0]       grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  bus_valid,
    output logic [WIDTH-1:0]      bus_data,
    output logic [CNT_W-1:0]      contention_cnt,
    output bus_state_e            state_o
);

    // Handshake: bus_valid=1 means bus_data holds the word of the source flagged
    // in grant/grant_idx, sampled at the most recent edge; no ready, no stall.

    bus_state_e       state_q, state_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [NSRC-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [WIDTH-1:0] src_words [NSRC];
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             hold;
    logic [IDX_W-1:0] sel_idx;

    for (genvar i = 0; i < NSRC; i++) begin : g_words
        assign src_words[i] = src_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(.NSRC(NSRC), .IDX_W(IDX_W)) u_pick (
        .req      (req),
        .last_idx (last_idx_q),
        .any      (pick_any),
        .win_idx  (pick_idx)
    );

    // A locked owner keeps the bus only while it keeps requesting.
    assign hold    = (state_q == OWNED) && lock && req[grant_idx_q];
    assign sel_idx = hold ? grant_idx_q : pick_idx;

    always_comb begin
        state_d     = IDLE;
        last_idx_d  = last_idx_q;
        grant_idx_d = grant_idx_q;
        grant_d     = '0;
        valid_d     = 1'b0;
        data_d      = data_q;
        if (hold || pick_any) begin
            state_d          = OWNED;
            grant_idx_d      = sel_idx;
            grant_d[sel_idx] = 1'b1;
            valid_d          = 1'b1;
            data_d           = src_words[sel_idx];
            if (!hold) begin
                last_idx_d = pick_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            last_idx_q  <= IDX_W'(NSRC - 1);
            grant_idx_q <= '0;
            grant_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_idx_q  <= last_idx_d;
            grant_idx_q <= grant_idx_d;
            grant_q     <= grant_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign bus_valid = valid_q;
    assign bus_data  = data_q;
    assign state_o   = state_q;

`ifdef BUS_RR_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic             multi_req;

    // Two or more set bits: clearing the lowest set bit leaves something.
    assign multi_req = |(req & (req - NSRC'(1)));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else if (!hold && pick_any && multi_req && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign contention_cnt = cnt_q;
`else
    assign contention_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_bus_rr_arbiter;
    import bus_pkg::*;

    localparam int WIDTH = 32;
    localparam int NSRC  = 24;
    localparam int IDX_W = 5;
    localparam int N_VEC = 9;

    logic                  clk = 1'b0;
    logic                  clr_n;
    logic [NSRC-1:0]       req;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  lock;
    logic [NSRC-1:0]       grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  bus_valid;
    logic [WIDTH-1:0]      bus_data;
    logic [15:0]           contention_cnt;
    bus_state_e            state_o;

    bus_rr_arbiter #(.WIDTH(WIDTH), .NSRC(NSRC), .IDX_W(IDX_W)) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .req            (req),
        .src_data       (src_data),
        .lock           (lock),
        .grant          (grant),
        .grant_idx      (grant_idx),
        .bus_valid      (bus_valid),
        .bus_data       (bus_data),
        .contention_cnt (contention_cnt),
        .state_o        (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] words [NSRC];
    bit               m_valid;
    int               m_owner;
    int               m_last;
    logic [WIDTH-1:0] m_data;
    int               m_cnt;

    task automatic model_reset();
        m_valid = 0;
        m_owner = 0;
        m_last  = NSRC - 1;
        m_data  = '0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        int  winner;
        bit  arb;
        winner = -1;
        arb    = 0;
        if (m_valid && lock && req[m_owner]) begin
            winner = m_owner;
        end else begin
            arb = 1;
            for (int k = 1; k <= NSRC; k++) begin
                int idx;
                idx = (m_last + k) % NSRC;
                if (winner < 0 && req[idx]) winner = idx;
            end
        end
`ifdef BUS_RR_STATS_EN
        if (arb && $countones(req) >= 2 && m_cnt < 16'hFFFF) m_cnt++;
`endif
        if (winner >= 0) begin
            m_valid = 1;
            m_owner = winner;
            m_data  = words[winner];
            if (arb) m_last = winner;
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [NSRC-1:0] exp_g;
        exp_g = '0;
        if (m_valid) exp_g[m_owner] = 1'b1;
        check({tag, ".bus_valid"}, 64'(bus_valid), 64'(m_valid));
        check({tag, ".grant"}, 64'(grant), 64'(exp_g));
        if (m_valid) check({tag, ".grant_idx"}, 64'(grant_idx), 64'(m_owner));
        check({tag, ".bus_data"}, 64'(bus_data), 64'(m_data));
        check({tag, ".cnt"}, 64'(contention_cnt), 64'(m_cnt));
        check({tag, ".state"}, 64'(state_o), 64'(m_valid ? OWNED : IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_word(input int i, input logic [WIDTH-1:0] w);
        words[i] = w;
        src_data[i*WIDTH +: WIDTH] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        req   = '0;
        lock  = 1'b0;
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    // Drive inputs, step the model at the edge, sample #1 later.
    task automatic cycle(input logic [NSRC-1:0] r, input logic l);
        req  = r;
        lock = l;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [NSRC-1:0] req;
        logic            lock;
        logic            valid;
        int              idx;
    } vec_t;

    vec_t tbl [N_VEC];

    initial begin
        logic [NSRC-1:0]  exp_g;
        logic [WIDTH-1:0] last_data;
        logic [NSRC-1:0]  r;

        clr_n    = 1'b0;
        req      = '0;
        lock     = 1'b0;
        src_data = '0;
        for (int i = 0; i < NSRC; i++) words[i] = '0;
        model_reset();

        tbl[0] = '{24'h000001, 1'b0, 1'b1, 0};
        tbl[1] = '{24'h000006, 1'b0, 1'b1, 1};
        tbl[2] = '{24'h000006, 1'b1, 1'b1, 1};
        tbl[3] = '{24'h000006, 1'b0, 1'b1, 2};
        tbl[4] = '{24'h000000, 1'b0, 1'b0, 0};
        tbl[5] = '{24'h800000, 1'b0, 1'b1, 23};
        tbl[6] = '{24'h800001, 1'b0, 1'b1, 0};
        tbl[7] = '{24'h800001, 1'b0, 1'b1, 23};
        tbl[8] = '{24'h000001, 1'b1, 1'b1, 0};

        // Reset state
        do_reset();
        check("reset.grant", 64'(grant), 64'h0);
        check("reset.grant_idx", 64'(grant_idx), 64'h0);
        check("reset.bus_valid", 64'(bus_valid), 64'h0);
        check("reset.bus_data", 64'(bus_data), 64'h0);
        check("reset.cnt", 64'(contention_cnt), 64'h0);

        // Table
        for (int i = 0; i < NSRC; i++) set_word(i, 32'hA000_0000 + 32'(i));
        last_data = '0;
        for (int v = 0; v < N_VEC; v++) begin
            cycle(tbl[v].req, tbl[v].lock);
            exp_g = '0;
            if (tbl[v].valid) exp_g[tbl[v].idx] = 1'b1;
            check($sformatf("tbl%0d.valid", v), 64'(bus_valid), 64'(tbl[v].valid));
            check($sformatf("tbl%0d.grant", v), 64'(grant), 64'(exp_g));
            if (tbl[v].valid) begin
                last_data = 32'hA000_0000 + 32'(tbl[v].idx);
                check($sformatf("tbl%0d.idx", v), 64'(grant_idx), 64'(tbl[v].idx));
            end
            check($sformatf("tbl%0d.data", v), 64'(bus_data), 64'(last_data));
        end

        // First grant after reset
        do_reset();
        set_word(0, 32'hDEADBEEF);
        cycle(24'h000001, 1'b0);
        check("first.grant", 64'(grant), 64'h1);
        check("first.grant_idx", 64'(grant_idx), 64'h0);
        check("first.bus_valid", 64'(bus_valid), 64'h1);
        check("first.bus_data", 64'(bus_data), 64'hDEADBEEF);
        check_model("first");

        // All sources requesting: strict rotation
        do_reset();
        for (int i = 0; i < NSRC; i++) begin
            cycle('1, 1'b0);
            check($sformatf("rot%0d.idx", i), 64'(grant_idx), 64'(i));
            check_model("rot");
        end
`ifdef BUS_RR_STATS_EN
        check("rot.cnt24", 64'(contention_cnt), 64'd24);
`else
        check("rot.cnt0", 64'(contention_cnt), 64'd0);
`endif
        cycle('1, 1'b0);
        check("rot.wrap", 64'(grant_idx), 64'h0);

        // Lock hold then handover, then release to idle
        do_reset();
        cycle(24'h000020, 1'b0);
        check("lock.own5", 64'(grant_idx), 64'd5);
        repeat (4) begin
            cycle(24'h000220, 1'b1);
            check("lock.hold5", 64'(grant_idx), 64'd5);
            check_model("lock");
        end
        cycle(24'h000200, 1'b1);
        check("lock.hand9", 64'(grant_idx), 64'd9);
        check("lock.valid", 64'(bus_valid), 64'h1);
        cycle(24'h000000, 1'b0);
        check("rel.valid", 64'(bus_valid), 64'h0);
        check("rel.grant", 64'(grant), 64'h0);
        check("rel.data", 64'(bus_data), 64'(words[9]));
        check_model("rel");

        // Asynchronous reset mid-transfer
        do_reset();
        cycle(24'h000008, 1'b0);
        check("arst.own3", 64'(grant_idx), 64'd3);
        #2;
        clr_n = 1'b0;
        model_reset();
        #1;
        check("arst.grant", 64'(grant), 64'h0);
        check("arst.valid", 64'(bus_valid), 64'h0);
        check("arst.data", 64'(bus_data), 64'h0);
        check("arst.idx", 64'(grant_idx), 64'h0);
        @(negedge clk);
        clr_n = 1'b1;
        cycle(24'h000018, 1'b0);
        check("arst.win3", 64'(grant_idx), 64'd3);
        check_model("arst");

        // Randomized traffic against the model
        do_reset();
        repeat (400) begin
            for (int i = 0; i < NSRC; i++) set_word(i, $urandom());
            case ($urandom_range(0, 3))
                0: r = '0;
                1: begin r = '0; r[$urandom_range(0, NSRC-1)] = 1'b1; end
                2: r = NSRC'($urandom() & $urandom() & $urandom());
                default: r = NSRC'($urandom());
            endcase
            if (m_valid && $urandom_range(0, 1) == 1) r[m_owner] = 1'b1;
            cycle(r, 1'($urandom_range(0, 1)));
            check_model("rnd");
        end

        // Counter saturation / tie-off
        do_reset();
`ifdef BUS_RR_STATS_EN
        repeat (65540) cycle('1, 1'b0);
        check("sat.cnt", 64'(contention_cnt), 64'hFFFF);
`else
        repeat (30) cycle('1, 1'b0);
        check("off.cnt", 64'(contention_cnt), 64'h0);
`endif
        check_model("sat");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
